// File: rtl/ibex_xif_offload_ctrl.sv
// Offload controller between the ID stage and an XIF coprocessor: issue handshake,
// one commit/kill per issued ID, scoreboard of outstanding IDs and result write-back.
module ibex_xif_offload_ctrl #(
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned MAX_INFLIGHT = 4,
    localparam int unsigned CntW        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                id_instr_valid_i,
    input  logic [31:0]         id_instr_i,
    input  logic [31:0]         id_rs1_i,
    input  logic [31:0]         id_rs2_i,
    input  logic                id_flush_i,
    output logic                id_stall_o,
    output logic                id_accept_o,
    output logic                id_illegal_o,

    output logic                x_issue_valid_o,
    input  logic                x_issue_ready_i,
    output logic [31:0]         x_issue_instr_o,
    output logic [ID_WIDTH-1:0] x_issue_id_o,
    output logic [63:0]         x_issue_rs_o,
    input  logic                x_issue_accept_i,

    output logic                x_commit_valid_o,
    output logic [ID_WIDTH-1:0] x_commit_id_o,
    output logic                x_commit_kill_o,

    input  logic                x_result_valid_i,
    output logic                x_result_ready_o,
    input  logic [ID_WIDTH-1:0] x_result_id_i,
    input  logic [4:0]          x_result_rd_i,
    input  logic [31:0]         x_result_data_i,
    input  logic                x_result_we_i,

    output logic                rf_we_o,
    output logic [4:0]          rf_waddr_o,
    output logic [31:0]         rf_wdata_o,
    output logic                result_err_o,
    output logic [CntW-1:0]     inflight_cnt_o
);

    localparam int unsigned NumIds = 2 ** ID_WIDTH;

    if (MAX_INFLIGHT > NumIds) begin : g_bad_cfg
        $error("MAX_INFLIGHT must not exceed 2**ID_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] id_cnt_q, id_cnt_d;
    logic [ID_WIDTH-1:0] cmt_id_q, cmt_id_d;
    logic [31:0]         instr_q, instr_d;
    logic [31:0]         rs1_q, rs1_d;
    logic [31:0]         rs2_q, rs2_d;
    logic                kill_q, kill_d;
    logic                acc_q, acc_d;
    logic                ill_q, ill_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NumIds-1:0]   sb_q, sb_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_waddr_q, rf_waddr_d;
    logic [31:0]         rf_wdata_q, rf_wdata_d;
    logic                err_q, err_d;
    logic                full;
    logic                sb_set;
    logic                res_hit;

    assign full = (cnt_q >= CntW'(MAX_INFLIGHT));

    always_comb begin
        state_d          = state_q;
        id_cnt_d         = id_cnt_q;
        cmt_id_d         = cmt_id_q;
        instr_d          = instr_q;
        rs1_d            = rs1_q;
        rs2_d            = rs2_q;
        kill_d           = kill_q;
        acc_d            = acc_q;
        ill_d            = ill_q;
        x_issue_valid_o  = 1'b0;
        x_commit_valid_o = 1'b0;
        id_accept_o      = 1'b0;
        id_illegal_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (id_instr_valid_i && !id_flush_i && !full) begin
                    instr_d = id_instr_i;
                    rs1_d   = id_rs1_i;
                    rs2_d   = id_rs2_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                x_issue_valid_o = 1'b1;
                if (x_issue_ready_i) begin
                    // A flush coinciding with the handshake turns the offload into a kill.
                    id_cnt_d = id_cnt_q + 1'b1;
                    cmt_id_d = id_cnt_q;
                    kill_d   = !x_issue_accept_i || id_flush_i;
                    acc_d    = x_issue_accept_i && !id_flush_i;
                    ill_d    = !x_issue_accept_i && !id_flush_i;
                    state_d  = StCommit;
                end else if (id_flush_i) begin
                    state_d = StIdle;
                end
            end
            StCommit: begin
                x_commit_valid_o = 1'b1;
                id_accept_o      = acc_q;
                id_illegal_o     = ill_q;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign sb_set  = (state_q == StCommit) && acc_q;
    assign res_hit = x_result_valid_i && sb_q[x_result_id_i];

    always_comb begin
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = x_result_valid_i && !sb_q[x_result_id_i];
        if (sb_set) begin
            sb_d[cmt_id_q] = 1'b1;
        end
        if (res_hit) begin
            sb_d[x_result_id_i] = 1'b0;
            rf_we_d             = x_result_we_i && (x_result_rd_i != 5'd0);
            rf_waddr_d          = x_result_rd_i;
            rf_wdata_d          = x_result_data_i;
        end
        case ({sb_set, res_hit})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            id_cnt_q   <= '0;
            cmt_id_q   <= '0;
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            kill_q     <= 1'b0;
            acc_q      <= 1'b0;
            ill_q      <= 1'b0;
            cnt_q      <= '0;
            sb_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_cnt_q   <= id_cnt_d;
            cmt_id_q   <= cmt_id_d;
            instr_q    <= instr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            kill_q     <= kill_d;
            acc_q      <= acc_d;
            ill_q      <= ill_d;
            cnt_q      <= cnt_d;
            sb_q       <= sb_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign id_stall_o       = (state_q != StIdle) || (id_instr_valid_i && full);
    assign x_issue_instr_o  = instr_q;
    assign x_issue_rs_o     = {rs2_q, rs1_q};
    assign x_issue_id_o     = id_cnt_q;
    assign x_commit_id_o    = x_commit_valid_o ? cmt_id_q : '0;
    assign x_commit_kill_o  = x_commit_valid_o && kill_q;
    assign x_result_ready_o = 1'b1;
    assign rf_we_o          = rf_we_q;
    assign rf_waddr_o       = rf_waddr_q;
    assign rf_wdata_o       = rf_wdata_q;
    assign result_err_o     = err_q;
    assign inflight_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ibex_xif_offload_ctrl.sv
// Randomised bench for ibex_xif_offload_ctrl; a set/counter model of outstanding IDs
// predicts issue IDs, commit kills, pulses, RF writes and the inflight count.
module tb_ibex_xif_offload_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_instr_valid_i, id_flush_i, id_stall_o, id_accept_o, id_illegal_o;
    logic [31:0] id_instr_i, id_rs1_i, id_rs2_i;
    logic        x_issue_valid_o, x_issue_ready_i, x_issue_accept_i;
    logic [31:0] x_issue_instr_o;
    logic [3:0]  x_issue_id_o, x_commit_id_o, x_result_id_i;
    logic [63:0] x_issue_rs_o;
    logic        x_commit_valid_o, x_commit_kill_o;
    logic        x_result_valid_i, x_result_ready_o, x_result_we_i;
    logic [4:0]  x_result_rd_i, rf_waddr_o;
    logic [31:0] x_result_data_i, rf_wdata_o;
    logic        rf_we_o, result_err_o;
    logic [2:0]  inflight_cnt_o;

    ibex_xif_offload_ctrl #(.ID_WIDTH(4), .MAX_INFLIGHT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_instr_valid_i(id_instr_valid_i), .id_instr_i(id_instr_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_flush_i(id_flush_i),
        .id_stall_o(id_stall_o), .id_accept_o(id_accept_o), .id_illegal_o(id_illegal_o),
        .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
        .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
        .x_issue_rs_o(x_issue_rs_o), .x_issue_accept_i(x_issue_accept_i),
        .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
        .x_commit_kill_o(x_commit_kill_o),
        .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
        .x_result_id_i(x_result_id_i), .x_result_rd_i(x_result_rd_i),
        .x_result_data_i(x_result_data_i), .x_result_we_i(x_result_we_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .result_err_o(result_err_o), .inflight_cnt_o(inflight_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb_m;
    int          cnt_m;
    logic [3:0]  id_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        sb_m  = '0;
        cnt_m = 0;
        id_m  = '0;
    endtask

    // Drives one offload from IDLE through commit (or flush) and checks every cycle.
    task automatic do_offload(input bit acc, input int delay, input bit fl_pre, input bit fl_hs,
                              input logic [31:0] ins, output logic [3:0] iid);
        logic [31:0] r1, r2;
        r1 = $urandom;
        r2 = $urandom;
        iid = id_m;
        id_instr_valid_i = 1'b1;
        id_instr_i = ins; id_rs1_i = r1; id_rs2_i = r2;
        id_flush_i = 1'b0; x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0;
        #1 check_eq("stall_c0", id_stall_o, 0);
        tick();
        for (int d = 0; d < delay; d++) begin
            #1;
            check_eq("issue_valid_bp", x_issue_valid_o, 1);
            check_eq("issue_id_bp", x_issue_id_o, id_m);
            check_eq("issue_instr_bp", x_issue_instr_o, ins);
            check_eq("issue_rs_bp", x_issue_rs_o, {r2, r1});
            check_eq("stall_bp", id_stall_o, 1);
            tick();
        end
        if (fl_pre) begin
            id_flush_i = 1'b1;
            tick();
            id_flush_i = 1'b0;
            id_instr_valid_i = 1'b0;
            #1;
            check_eq("flush_issue_valid", x_issue_valid_o, 0);
            check_eq("flush_no_commit", x_commit_valid_o, 0);
            check_eq("flush_stall", id_stall_o, 0);
            tick();
            #1 check_eq("flush_no_commit2", x_commit_valid_o, 0);
            return;
        end
        x_issue_ready_i = 1'b1; x_issue_accept_i = acc; id_flush_i = fl_hs;
        #1;
        check_eq("issue_valid", x_issue_valid_o, 1);
        check_eq("issue_id", x_issue_id_o, id_m);
        check_eq("issue_instr", x_issue_instr_o, ins);
        tick();
        id_instr_valid_i = 1'b0; x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0;
        id_flush_i = 1'b0;
        #1;
        check_eq("commit_valid", x_commit_valid_o, 1);
        check_eq("commit_id", x_commit_id_o, id_m);
        check_eq("commit_kill", x_commit_kill_o, !acc || fl_hs);
        check_eq("accept_pulse", id_accept_o, acc && !fl_hs);
        check_eq("illegal_pulse", id_illegal_o, !acc && !fl_hs);
        check_eq("stall_c2", id_stall_o, 1);
        if (acc && !fl_hs) begin
            sb_m[id_m] = 1'b1;
            cnt_m++;
        end
        id_m = id_m + 4'd1;
        tick();
        #1;
        check_eq("commit_done", x_commit_valid_o, 0);
        check_eq("accept_done", id_accept_o, 0);
        check_eq("stall_c3", id_stall_o, 0);
        check_eq("inflight", inflight_cnt_o, cnt_m);
    endtask

    task automatic do_result(input logic [3:0] rid, input logic [4:0] rd, input logic [31:0] data,
                             input bit we);
        bit hit;
        hit = sb_m[rid];
        x_result_valid_i = 1'b1;
        x_result_id_i = rid; x_result_rd_i = rd; x_result_data_i = data; x_result_we_i = we;
        #1 check_eq("result_ready", x_result_ready_o, 1);
        tick();
        x_result_valid_i = 1'b0;
        #1;
        if (hit) begin
            sb_m[rid] = 1'b0;
            cnt_m--;
            check_eq("rf_we", rf_we_o, we && (rd != 0));
            if (we && rd != 0) begin
                check_eq("rf_waddr", rf_waddr_o, rd);
                check_eq("rf_wdata", rf_wdata_o, data);
            end
            check_eq("result_err_hit", result_err_o, 0);
        end else begin
            check_eq("result_err", result_err_o, 1);
            check_eq("rf_we_bogus", rf_we_o, 0);
        end
        check_eq("inflight_res", inflight_cnt_o, cnt_m);
        tick();
        #1;
        check_eq("rf_we_one_cycle", rf_we_o, 0);
        check_eq("err_one_cycle", result_err_o, 0);
    endtask

    task automatic retire_all();
        for (int i = 0; i < 16; i++) begin
            if (sb_m[i]) do_result(4'(i), 5'($urandom_range(1, 31)), $urandom, 1'b1);
        end
    endtask

    logic [3:0]  iid, first_id, rid;
    logic [31:0] ins;

    initial begin
        rst_ni = 1'b0;
        id_instr_valid_i = 0; id_instr_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_flush_i = 0;
        x_issue_ready_i = 0; x_issue_accept_i = 0;
        x_result_valid_i = 0; x_result_id_i = 0; x_result_rd_i = 0; x_result_data_i = 0;
        x_result_we_i = 0;
        model_reset();
        #1;
        check_eq("rst_stall", id_stall_o, 0);
        check_eq("rst_issue_valid", x_issue_valid_o, 0);
        check_eq("rst_issue_id", x_issue_id_o, 0);
        check_eq("rst_commit_valid", x_commit_valid_o, 0);
        check_eq("rst_accept", id_accept_o, 0);
        check_eq("rst_illegal", id_illegal_o, 0);
        check_eq("rst_rf_we", rf_we_o, 0);
        check_eq("rst_err", result_err_o, 0);
        check_eq("rst_inflight", inflight_cnt_o, 0);
        check_eq("rst_result_ready", x_result_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Accept, reject, backpressure with flush, reuse of the flushed ID.
        do_offload(1, 0, 0, 0, 32'h0000_000B, iid);
        do_result(iid, 5'd5, 32'hDEAD_BEEF, 1'b1);
        do_offload(0, 0, 0, 0, $urandom, iid);
        do_offload(1, 3, 1, 0, $urandom, iid);
        do_offload(1, 1, 0, 0, $urandom, iid);
        do_result(iid, 5'd0, $urandom, 1'b1);

        // Fill the scoreboard, then the fifth request must wait for a retirement.
        first_id = id_m;
        for (int i = 0; i < 4; i++) do_offload(1, 0, 0, 0, $urandom, iid);
        ins = $urandom;
        id_instr_valid_i = 1'b1; id_instr_i = ins;
        #1 check_eq("full_stall", id_stall_o, 1);
        tick();
        #1;
        check_eq("full_stall2", id_stall_o, 1);
        check_eq("full_no_issue", x_issue_valid_o, 0);
        x_result_valid_i = 1'b1; x_result_id_i = first_id; x_result_rd_i = 5'd7;
        x_result_data_i = 32'h1234_5678; x_result_we_i = 1'b1;
        tick();
        x_result_valid_i = 1'b0;
        sb_m[first_id] = 1'b0; cnt_m--;
        #1;
        check_eq("full_rf_we", rf_we_o, 1);
        check_eq("full_release", id_stall_o, 0);
        check_eq("full_inflight", inflight_cnt_o, cnt_m);
        tick();
        x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1;
        #1;
        check_eq("fifth_issue_valid", x_issue_valid_o, 1);
        check_eq("fifth_issue_id", x_issue_id_o, id_m);
        tick();
        id_instr_valid_i = 1'b0; x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0;
        #1 check_eq("fifth_accept", id_accept_o, 1);
        sb_m[id_m] = 1'b1; cnt_m++; id_m = id_m + 4'd1;
        tick();
        #1 check_eq("fifth_inflight", inflight_cnt_o, cnt_m);
        retire_all();

        // Flush landing on the handshake, then a result for an unallocated ID.
        do_offload(1, 0, 0, 1, $urandom, iid);
        do_result(iid, 5'd3, $urandom, 1'b1);

        // Reset in the middle of an issue with one offload outstanding.
        do_offload(1, 0, 0, 0, $urandom, iid);
        id_instr_valid_i = 1'b1; id_instr_i = $urandom;
        tick();
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_eq("mrst_issue_valid", x_issue_valid_o, 0);
        check_eq("mrst_inflight", inflight_cnt_o, 0);
        id_instr_valid_i = 1'b0;
        tick();
        #1 check_eq("mrst_no_commit", x_commit_valid_o, 0);
        rst_ni = 1'b1;
        tick();

        // Seventeen retired offloads show the ID wrap.
        for (int i = 0; i < 17; i++) begin
            do_offload(1, $urandom_range(0, 2), 0, 0, $urandom, iid);
            do_result(iid, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
        end

        for (int n = 0; n < 300; n++) begin
            if (cnt_m < 4 && $urandom_range(0, 9) < 6) begin
                bit fp;
                fp = ($urandom_range(0, 9) == 0);
                do_offload($urandom_range(0, 3) != 0, $urandom_range(0, 3), fp,
                           !fp && ($urandom_range(0, 9) == 0), $urandom, iid);
            end else begin
                rid = 4'($urandom_range(0, 15));
                if (cnt_m > 0 && $urandom_range(0, 7) != 0) begin
                    while (!sb_m[rid]) rid = rid + 4'd1;
                end
                do_result(rid, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
